// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: shares one single-cycle ALU between two requesters.
// Round-robin grant on ties, operands captured at acceptance, a one-cycle
// execute slot on the ALU, and a registered response held until taken.
// Opcodes outside the ALU's legal set return err=1 with zero data.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_s
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Legal ALU encodings: add, sub, and, or, xor, sll, srl, sra, slt, sltu.
  function automatic logic op_legal(input logic [OPW-1:0] op);
    logic ok;
    case (op)
      OPW'(4'b0000): ok = 1'b1;
      OPW'(4'b1000): ok = 1'b1;
      OPW'(4'b0111): ok = 1'b1;
      OPW'(4'b0110): ok = 1'b1;
      OPW'(4'b0100): ok = 1'b1;
      OPW'(4'b0001): ok = 1'b1;
      OPW'(4'b0101): ok = 1'b1;
      OPW'(4'b1101): ok = 1'b1;
      OPW'(4'b0010): ok = 1'b1;
      OPW'(4'b0011): ok = 1'b1;
      default:       ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t           state_q, state_d;
  logic             prio_q, prio_d;
  logic             gnt_q, gnt_d;
  // The operand/op registers feed the ALU directly; they are only non-zero
  // during EXEC, so the ALU inputs read zero in every other state.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             rsp0_valid_q, rsp0_valid_d;
  logic             rsp1_valid_q, rsp1_valid_d;
  logic [WIDTH-1:0] rsp0_data_q, rsp0_data_d;
  logic [WIDTH-1:0] rsp1_data_q, rsp1_data_d;
  logic             rsp0_err_q, rsp0_err_d;
  logic             rsp1_err_q, rsp1_err_d;

  logic             any_req_s;
  logic             gnt_s;
  logic             legal_s;
  logic             rsp_take_s;

  // Grant selection: single valid requester wins, ties go to prio.
  always_comb begin
    any_req_s = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      gnt_s = prio_q;
    end else if (req1_valid) begin
      gnt_s = 1'b1;
    end else begin
      gnt_s = 1'b0;
    end
    legal_s    = op_legal(op_q);
    rsp_take_s = gnt_q ? rsp1_ready : rsp0_ready;
  end

  // Next-state and handshake logic for the IDLE -> EXEC -> RESP sequence.
  always_comb begin
    state_d      = state_q;
    prio_d       = prio_q;
    gnt_d        = gnt_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp1_data_d  = rsp1_data_q;
    rsp0_err_d   = rsp0_err_q;
    rsp1_err_d   = rsp1_err_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (any_req_s) begin
          req0_ready = ~gnt_s;
          req1_ready = gnt_s;
          gnt_d      = gnt_s;
          a_d        = gnt_s ? req1_a  : req0_a;
          b_d        = gnt_s ? req1_b  : req0_b;
          op_d       = gnt_s ? req1_op : req0_op;
          state_d    = ST_EXEC;
        end else begin
          state_d    = ST_IDLE;
        end
      end
      ST_EXEC: begin
        // Result captured from the ALU this cycle; illegal ops return zero.
        if (gnt_q) begin
          rsp1_valid_d = 1'b1;
          rsp1_data_d  = legal_s ? alu_s : {WIDTH{1'b0}};
          rsp1_err_d   = ~legal_s;
        end else begin
          rsp0_valid_d = 1'b1;
          rsp0_data_d  = legal_s ? alu_s : {WIDTH{1'b0}};
          rsp0_err_d   = ~legal_s;
        end
        a_d     = {WIDTH{1'b0}};
        b_d     = {WIDTH{1'b0}};
        op_d    = {OPW{1'b0}};
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_take_s) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          rsp0_data_d  = {WIDTH{1'b0}};
          rsp1_data_d  = {WIDTH{1'b0}};
          rsp0_err_d   = 1'b0;
          rsp1_err_d   = 1'b0;
          prio_d       = ~gnt_q;
          state_d      = ST_IDLE;
        end else begin
          state_d      = ST_RESP;
        end
      end
      default: begin
        a_d          = {WIDTH{1'b0}};
        b_d          = {WIDTH{1'b0}};
        op_d         = {OPW{1'b0}};
        rsp0_valid_d = 1'b0;
        rsp1_valid_d = 1'b0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset; reset drops any
  // in-flight transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      prio_q       <= 1'b0;
      gnt_q        <= 1'b0;
      a_q          <= {WIDTH{1'b0}};
      b_q          <= {WIDTH{1'b0}};
      op_q         <= {OPW{1'b0}};
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
      rsp0_data_q  <= {WIDTH{1'b0}};
      rsp1_data_q  <= {WIDTH{1'b0}};
      rsp0_err_q   <= 1'b0;
      rsp1_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      prio_q       <= prio_d;
      gnt_q        <= gnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp0_err_q   <= rsp0_err_d;
      rsp1_err_q   <= rsp1_err_d;
    end
  end

  assign alu_a      = a_q;
  assign alu_b      = b_q;
  assign alu_op     = op_q;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp0_data  = rsp0_data_q;
  assign rsp1_data  = rsp1_data_q;
  assign rsp0_err   = rsp0_err_q;
  assign rsp1_err   = rsp1_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: directed vectors, expected responses queued
// by the stimulus thread and compared by an independent response monitor.
// A behavioural ALU model sits on the alu_* side.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = 32'd0, req0_b = 32'd0, req1_a = 32'd0, req1_b = 32'd0;
  logic [3:0]  req0_op = 4'd0, req1_op = 4'd0;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready = 1'b1, rsp1_ready = 1'b1;
  logic [31:0] rsp0_data, rsp1_data;
  logic        rsp0_err, rsp1_err;
  logic [31:0] alu_a, alu_b, alu_s;
  logic [3:0]  alu_op;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct packed {
    logic        id;
    logic [31:0] data;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  alu_share_arbiter #(.WIDTH(32), .OPW(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data), .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data), .rsp1_err(rsp1_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_s(alu_s)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Behavioural ALU; unknown opcodes return a marker so forcing to zero is visible.
  always_comb begin
    case (alu_op)
      4'b0000: alu_s = alu_a + alu_b;
      4'b1000: alu_s = alu_a - alu_b;
      4'b0111: alu_s = alu_a & alu_b;
      4'b0110: alu_s = alu_a | alu_b;
      4'b0100: alu_s = alu_a ^ alu_b;
      4'b0001: alu_s = alu_a << alu_b[4:0];
      4'b0101: alu_s = alu_a >> alu_b[4:0];
      4'b1101: alu_s = $signed(alu_a) >>> alu_b[4:0];
      4'b0010: alu_s = {31'd0, $signed(alu_a) < $signed(alu_b)};
      4'b0011: alu_s = {31'd0, alu_a < alu_b};
      default: alu_s = 32'hDEAD_BEEF;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_rsp(input logic id, input logic [31:0] data, input logic err);
    exp_t e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $display("FAIL unexpected_rsp: got rsp%0d data 0x%08h, expected no response", id, data);
    end else begin
      e = exp_q.pop_front();
      chk("rsp_id", {31'd0, id}, {31'd0, e.id});
      chk("rsp_data", data, e.data);
      chk("rsp_err", {31'd0, err}, {31'd0, e.err});
    end
  endtask

  // Response monitor: compares every handshake against the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp0_valid || rsp1_valid)
        chk("excl_valid", {31'd0, rsp0_valid & rsp1_valid}, 32'd0);
      if (rsp0_valid && rsp0_ready) check_rsp(1'b0, rsp0_data, rsp0_err);
      if (rsp1_valid && rsp1_ready) check_rsp(1'b1, rsp1_data, rsp1_err);
    end
  end

  task automatic push(input logic id, input logic [31:0] data, input logic err);
    exp_t e;
    e.id = id; e.data = data; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_req(input logic n, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    if (n) begin
      req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
    end
  endtask

  // Waits for acceptance of requester n, checks the other is not granted, drops valid.
  task automatic wait_acc(input logic n, output int t_acc);
    bit seen;
    seen = 1'b0;
    t_acc = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((n ? req1_ready : req0_ready) === 1'b1) begin
        seen = 1'b1;
        t_acc = cyc;
        chk("other_ready", {31'd0, n ? req0_ready : req1_ready}, 32'd0);
        break;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL accept_timeout: req%0d never accepted within 50 cycles", n);
    end
    @(posedge clk);
    #1;
    if (n) req1_valid = 1'b0;
    else   req0_valid = 1'b0;
  endtask

  task automatic wait_rsp(input logic n, output int t_rsp);
    bit seen;
    seen = 1'b0;
    t_rsp = -1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if ((n ? rsp1_valid : rsp0_valid) === 1'b1) begin
        seen = 1'b1;
        t_rsp = cyc;
        break;
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL rsp_timeout: rsp%0d never valid within 50 cycles", n);
    end
  endtask

  task automatic check_quiet(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(name, {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    end
  endtask

  initial begin
    int t_acc, t_rsp, last;
    logic g;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    chk("rst_valid", {30'd0, rsp1_valid, rsp0_valid}, 32'd0);
    chk("rst_data0", rsp0_data, 32'd0);
    chk("rst_data1", rsp1_data, 32'd0);
    chk("rst_err", {30'd0, rsp1_err, rsp0_err}, 32'd0);
    chk("rst_alu", alu_a | alu_b | {28'd0, alu_op}, 32'd0);

    // 1: req0 add 5+7, latency T -> T+2, ALU driven only in EXEC
    @(posedge clk); #1;
    push(1'b0, 32'h0000000C, 1'b0);
    set_req(1'b0, 32'd5, 32'd7, 4'b0000);
    wait_acc(1'b0, t_acc);
    @(negedge clk);
    chk("exec_alu_a", alu_a, 32'd5);
    chk("exec_alu_b", alu_b, 32'd7);
    chk("exec_alu_op", {28'd0, alu_op}, 32'd0);
    chk("exec_no_valid", {31'd0, rsp0_valid}, 32'd0);
    wait_rsp(1'b0, t_rsp);
    chk("latency", t_rsp - t_acc, 32'd2);
    chk("resp_alu_a", alu_a, 32'd0);

    // 2: tie after reset, req0 sub first, then req1 xor
    @(posedge clk); #1;
    do_reset();
    push(1'b0, 32'hFFFFFFFE, 1'b0);
    push(1'b1, 32'h00000002, 1'b0);
    set_req(1'b0, 32'd5, 32'd7, 4'b1000);
    set_req(1'b1, 32'd5, 32'd7, 4'b0100);
    wait_acc(1'b0, t_acc);
    wait_acc(1'b1, t_acc);
    wait_rsp(1'b1, t_rsp);
    @(posedge clk); #1;

    // 3: both held valid for 4 ops, grants alternate every 3 cycles
    push(1'b0, 32'd3, 1'b0);
    push(1'b1, 32'd7, 1'b0);
    push(1'b0, 32'd3, 1'b0);
    push(1'b1, 32'd7, 1'b0);
    set_req(1'b0, 32'd1, 32'd2, 4'b0000);
    set_req(1'b1, 32'd10, 32'd3, 4'b1000);
    last = -1;
    for (int k = 0; k < 4; k++) begin
      g = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) break;
      end
      g = req1_ready;
      chk("t3_one_ready", {31'd0, req0_ready ^ req1_ready}, 32'd1);
      chk("t3_gnt", {31'd0, g}, k % 2);
      if (k > 0) chk("t3_interval", cyc - last, 32'd3);
      last = cyc;
      @(posedge clk);
    end
    #1 req0_valid = 1'b0;
    req1_valid = 1'b0;
    wait_rsp(1'b1, t_rsp);
    @(posedge clk); #1;

    // 4: req1 slt then sltu with response back-pressure
    push(1'b1, 32'd1, 1'b0);
    set_req(1'b1, 32'hFFFFFFFB, 32'd5, 4'b0010);
    wait_acc(1'b1, t_acc);
    wait_rsp(1'b1, t_rsp);
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    push(1'b1, 32'd0, 1'b0);
    push(1'b0, 32'd2, 1'b0);
    set_req(1'b1, 32'hFFFFFFFB, 32'd5, 4'b0011);
    wait_acc(1'b1, t_acc);
    wait_rsp(1'b1, t_rsp);
    @(posedge clk); #1;
    set_req(1'b0, 32'd1, 32'd1, 4'b0000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_valid", {31'd0, rsp1_valid}, 32'd1);
      chk("hold_data", rsp1_data, 32'd0);
      chk("hold_ready", {30'd0, req1_ready, req0_ready}, 32'd0);
    end
    @(posedge clk); #1;
    rsp1_ready = 1'b1;
    wait_acc(1'b0, t_acc);
    wait_rsp(1'b0, t_rsp);
    @(posedge clk); #1;

    // 5: illegal opcode, then a legal or
    push(1'b0, 32'd0, 1'b1);
    set_req(1'b0, 32'd5, 32'd7, 4'b1111);
    wait_acc(1'b0, t_acc);
    wait_rsp(1'b0, t_rsp);
    @(posedge clk); #1;
    push(1'b0, 32'd7, 1'b0);
    set_req(1'b0, 32'd5, 32'd7, 4'b0110);
    wait_acc(1'b0, t_acc);
    wait_rsp(1'b0, t_rsp);
    @(posedge clk); #1;

    // 6: reset during EXEC, then during RESP; transactions are dropped
    set_req(1'b0, 32'd5, 32'd7, 4'b0000);
    wait_acc(1'b0, t_acc);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_quiet("rst_exec_quiet", 4);
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    set_req(1'b1, 32'd5, 32'd7, 4'b0100);
    wait_acc(1'b1, t_acc);
    wait_rsp(1'b1, t_rsp);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rsp1_ready = 1'b1;
    check_quiet("rst_resp_quiet", 4);
    @(posedge clk); #1;
    push(1'b0, 32'd5, 1'b0);
    push(1'b1, 32'd8, 1'b0);
    set_req(1'b0, 32'd2, 32'd3, 4'b0000);
    set_req(1'b1, 32'd4, 32'd4, 4'b0000);
    wait_acc(1'b0, t_acc);
    wait_acc(1'b1, t_acc);

    // Drain outstanding expectations
    for (int i = 0; i < 30; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    chk("drain", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
